flex_pts_serializer: RTL and testbench
======================================

// Module: flex_pts_serializer
// PURPOSE
//  Parametrised parallel-to-serial serializer, the successor to the fixed 4-bit PTS shift register.
//  - Captures a NUM_BITS word through a valid/ready load handshake.
//  - Shifts the word out one bit per shift_enable cycle, in a configurable direction.
//  - Reports busy and frame completion.
//  - Sits between a word producer (FIFO/controller) and a serial line driver.
// PARAMETERS
//  NUM_BITS   4   data word width; legal range 2..32
//  SHIFT_MSB  1   1: MSB transmitted first; 0: LSB transmitted first
//  IDLE_BIT   1   line level driven on serial_out while idle; also the vacated-bit fill value
// PORTS
//  clk            in   1         system clock; all state updates on rising edge
//  n_rst          in   1         asynchronous reset, active-low
//  load_valid     in   1         producer presents parallel_in
//  load_ready     out  1         block can accept a word this cycle
//  parallel_in    in   NUM_BITS  word to transmit; sampled only on handshake
//  shift_enable   in   1         advance one bit this cycle; ignored when idle
//  serial_out     out  1         current serial bit
//  busy           out  1         frame in progress
//  frame_done     out  1         one-cycle pulse after the last bit of a frame is shifted
// BEHAVIOUR
//  - Reset (async, n_rst=0), immediate, independent of clk:
//    state=IDLE, shift reg=all IDLE_BIT, bit count=0.
//    Outputs: serial_out=IDLE_BIT, busy=0, frame_done=0, load_ready=1.
//  - FSM states:
//    IDLE  -> SHIFT  on load_valid&&load_ready.
//    SHIFT -> IDLE   on the last shift when no new load occurs.
//    SHIFT -> SHIFT  on the last shift when load_valid=1 (back-to-back frame).
//  - load_ready is combinational from state, count and shift_enable only (no load_valid path):
//    1 in IDLE, or in SHIFT when shift_enable=1 and count==FRAME_LEN-1.
//  - Handshake edge: the word is captured into the shift reg, count=0, busy=1 from the next cycle.
//  - serial_out is driven from flops only:
//    SHIFT: head bit of shift reg (MSB if SHIFT_MSB, else LSB).
//    IDLE: IDLE_BIT.
//    First bit appears in the cycle after the load edge.
//  - SHIFT, shift_enable=1: shift one position toward the head, fill vacated bit with IDLE_BIT, count++.
//  - SHIFT, shift_enable=0: all state held; serial_out stable.
//  - FRAME_LEN = NUM_BITS, or NUM_BITS+1 with parity.
//    Last shift is the edge with shift_enable=1 and count==FRAME_LEN-1.
//    frame_done=1 for exactly the following cycle (registered).
//    busy=0 the following cycle unless back-to-back.
//  - Back-to-back (load on last shift edge):
//    New word loaded, count=0, busy stays 1, frame_done still pulses.
//    Zero idle cycles between frames.
//  - load_valid while busy and not at the last shift: ignored; parallel_in is not sampled.
//  - Reset mid-frame: frame discarded, no frame_done, line returns to IDLE_BIT at once.
//  - Count width: $clog2(FRAME_LEN+1); no wrap beyond FRAME_LEN-1.
// CONFIGURATION
//  FLEX_PTS_PARITY_EN defined:
//    - Even parity bit (^parallel_in) captured at load.
//    - Transmitted after the last data bit; FRAME_LEN=NUM_BITS+1.
//    - frame_done follows the parity shift.
//  FLEX_PTS_PARITY_EN undefined:
//    - No parity logic; FRAME_LEN=NUM_BITS.
//  Port list identical in both builds.
// TESTING (NUM_BITS=4, SHIFT_MSB=1, IDLE_BIT=1 unless noted)
//  1 Reset, hold n_rst=0 for 2 clocks, release -> serial_out=1, busy=0, frame_done=0, load_ready=1.
//  2 Load 4'b1010, shift_enable held 1 -> serial_out 1,0,1,0 on cycles 1-4 after load;
//    frame_done=1 on cycle 5 only; busy=0 on cycle 5; serial_out=1.
//  3 SHIFT_MSB=0, load 4'b1100, shift_enable toggling 1,0,1,0... -> serial_out 0,0,1,1,
//    each bit held 2 cycles; one frame_done pulse.
//  4 Back-to-back: load 4'b0110, then load 4'b1001 on the last shift edge ->
//    serial_out 0,1,1,0,1,0,0,1 contiguous; busy never drops; frame_done pulses twice.
//  5 Reset mid-frame: load 4'b0000, assert n_rst=0 after 2 shifts ->
//    serial_out=1 immediately (asynchronously); no frame_done; next load starts a clean frame.
//  6 With FLEX_PTS_PARITY_EN, load 4'b1011 -> serial_out 1,0,1,1,1 (parity=1);
//    frame_done after the 5th bit.
//    Load 4'b0011 -> parity bit 0.

Source files
------------

// File: rtl/flex_pts_serializer.sv
// Parametrised parallel-to-serial serializer with valid/ready load and frame completion pulse.
// Optional even parity bit after the data word when FLEX_PTS_PARITY_EN is defined.
module flex_pts_serializer #(
   parameter int NUM_BITS  = 4,
   parameter int SHIFT_MSB = 1,
   parameter int IDLE_BIT  = 1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [NUM_BITS-1:0] parallel_in,
   input  logic                shift_enable,
   output logic                serial_out,
   output logic                busy,
   output logic                frame_done
);

`ifdef FLEX_PTS_PARITY_EN
   localparam int FRAME_LEN = NUM_BITS + 1;
`else
   localparam int FRAME_LEN = NUM_BITS;
`endif
   localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
   localparam logic             FILL     = (IDLE_BIT != 0) ? 1'b1 : 1'b0;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t               state_r, state_s;
   logic [FRAME_LEN-1:0] sreg_r, sreg_s, load_word_s, shifted_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic                 frame_done_r;
   logic                 last_shift_s;
   logic                 load_s;

`ifdef FLEX_PTS_PARITY_EN
   function automatic logic even_parity(input logic [NUM_BITS-1:0] d);
      return ^d;
   endfunction
`endif

   // Frame image at load and after one shift; the head bit always sits at the serial_out tap.
   always_comb begin
      load_word_s = {FRAME_LEN{FILL}};
      shifted_s   = sreg_r;
`ifdef FLEX_PTS_PARITY_EN
      if (SHIFT_MSB != 0) begin
         load_word_s = {parallel_in, even_parity(parallel_in)};
      end else begin
         load_word_s = {even_parity(parallel_in), parallel_in};
      end
`else
      load_word_s = parallel_in;
`endif
      if (SHIFT_MSB != 0) begin
         shifted_s = {sreg_r[FRAME_LEN-2:0], FILL};
      end else begin
         shifted_s = {FILL, sreg_r[FRAME_LEN-1:1]};
      end
   end

   // Next-state, handshake and datapath update.
   always_comb begin
      state_s      = state_r;
      sreg_s       = sreg_r;
      cnt_s        = cnt_r;
      last_shift_s = (state_r == ST_SHIFT) && shift_enable && (cnt_r == LAST_CNT);
      load_ready   = (state_r == ST_IDLE) || last_shift_s;
      load_s       = load_valid && load_ready;
      case (state_r)
         ST_IDLE: begin
            if (load_s) begin
               state_s = ST_SHIFT;
               sreg_s  = load_word_s;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (load_s) begin
               // back-to-back: the next word replaces the fully shifted frame
               state_s = ST_SHIFT;
               sreg_s  = load_word_s;
               cnt_s   = {CNT_W{1'b0}};
            end else if (last_shift_s) begin
               state_s = ST_IDLE;
               sreg_s  = shifted_s;
               cnt_s   = {CNT_W{1'b0}};
            end else if (shift_enable) begin
               sreg_s = shifted_s;
               cnt_s  = cnt_r + CNT_W'(1);
            end else begin
               state_s = ST_SHIFT;
            end
         end
         default: begin
            state_s = ST_IDLE;
            sreg_s  = {FRAME_LEN{FILL}};
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State and datapath registers; reset parks the line at the idle level.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r      <= ST_IDLE;
         sreg_r       <= {FRAME_LEN{FILL}};
         cnt_r        <= {CNT_W{1'b0}};
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         sreg_r       <= sreg_s;
         cnt_r        <= cnt_s;
         frame_done_r <= last_shift_s;
      end
   end

   // Vacated positions fill with the idle level, so the head tap idles correctly by itself.
   assign serial_out = (SHIFT_MSB != 0) ? sreg_r[FRAME_LEN-1] : sreg_r[0];
   assign busy       = (state_r == ST_SHIFT);
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_flex_pts_serializer.sv
// Randomized bench for flex_pts_serializer: two instances (MSB-first idle-high, LSB-first idle-low)
// compared every cycle against a frame-queue reference model.
module tb_flex_pts_serializer;

`ifdef FLEX_PTS_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       n_rst;
   logic       load_valid;
   logic       shift_enable;
   logic [3:0] pin_a;
   logic [4:0] pin_b;
   logic       lr_a, so_a, busy_a, fd_a;
   logic       lr_b, so_b, busy_b, fd_b;

   int checks = 0;
   int errors = 0;

   // Model: seq_m[i][0] is the bit currently on the line, rem_m[i] bits remain in the frame.
   logic [63:0] seq_m [2];
   int          rem_m [2];
   bit          busy_m[2];
   bit          done_m[2];
   int          nb    [2] = '{4, 5};
   bit          msb   [2] = '{1'b1, 1'b0};
   bit          idl   [2] = '{1'b1, 1'b0};

   flex_pts_serializer #(.NUM_BITS(4), .SHIFT_MSB(1), .IDLE_BIT(1)) dut_a (
      .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_ready(lr_a),
      .parallel_in(pin_a), .shift_enable(shift_enable), .serial_out(so_a),
      .busy(busy_a), .frame_done(fd_a));

   flex_pts_serializer #(.NUM_BITS(5), .SHIFT_MSB(0), .IDLE_BIT(0)) dut_b (
      .clk(clk), .n_rst(n_rst), .load_valid(load_valid), .load_ready(lr_b),
      .parallel_in(pin_b), .shift_enable(shift_enable), .serial_out(so_b),
      .busy(busy_b), .frame_done(fd_b));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] build(input logic [31:0] w, input int n, input bit m);
      logic [63:0] s = 64'd0;
      for (int k = 0; k < n; k++) s[k] = m ? w[n-1-k] : w[k];
      if (PAR != 0) s[n] = ^w;
      return s;
   endfunction

   function automatic bit ready_m(input int i, input bit se);
      return !busy_m[i] || (se && rem_m[i] == 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         busy_m[i] = 1'b0;
         done_m[i] = 1'b0;
         rem_m[i]  = 0;
         seq_m[i]  = 64'd0;
      end
   endtask

   task automatic chk_inst(input string tag, input int i, input logic so, input logic bz,
                           input logic fd, input logic lr, input bit se);
      check_eq({tag, ".serial_out"}, 32'(so), 32'(busy_m[i] ? seq_m[i][0] : idl[i]));
      check_eq({tag, ".busy"},       32'(bz), 32'(busy_m[i]));
      check_eq({tag, ".frame_done"}, 32'(fd), 32'(done_m[i]));
      check_eq({tag, ".load_ready"}, 32'(lr), 32'(ready_m(i, se)));
   endtask

   task automatic model_edge(input int i, input bit lv, input logic [31:0] w, input bit se);
      bit rdy  = ready_m(i, se);
      bit last = busy_m[i] && se && (rem_m[i] == 1);
      done_m[i] = last;
      if (busy_m[i] && se) begin
         seq_m[i] = seq_m[i] >> 1;
         rem_m[i]--;
      end
      if (lv && rdy) begin
         seq_m[i]  = build(w, nb[i], msb[i]);
         rem_m[i]  = nb[i] + PAR;
         busy_m[i] = 1'b1;
      end else if (last) begin
         busy_m[i] = 1'b0;
      end
   endtask

   task automatic step(input bit lv, input logic [3:0] wa, input logic [4:0] wb, input bit se);
      @(negedge clk);
      load_valid   = lv;
      pin_a        = wa;
      pin_b        = wb;
      shift_enable = se;
      #1;
      chk_inst("a", 0, so_a, busy_a, fd_a, lr_a, se);
      chk_inst("b", 1, so_b, busy_b, fd_b, lr_b, se);
      @(posedge clk);
      model_edge(0, lv, 32'(wa), se);
      model_edge(1, lv, 32'(wb), se);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      load_valid = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      model_reset();
      check_eq("rst.a.serial_out", 32'(so_a), 32'(1));
      check_eq("rst.a.busy",       32'(busy_a), 32'(0));
      check_eq("rst.a.frame_done", 32'(fd_a), 32'(0));
      check_eq("rst.b.serial_out", 32'(so_b), 32'(0));
      check_eq("rst.b.busy",       32'(busy_b), 32'(0));
      @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      n_rst        = 1'b0;
      load_valid   = 1'b0;
      shift_enable = 1'b0;
      pin_a        = 4'd0;
      pin_b        = 5'd0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      // reset state, then a single MSB-first frame with shift_enable held
      step(1'b0, 4'd0, 5'd0, 1'b1);
      step(1'b1, 4'b1010, 5'b01101, 1'b1);
      repeat (6) step(1'b0, 4'd0, 5'd0, 1'b1);

      // shift_enable toggling: every bit held two cycles
      step(1'b1, 4'b1100, 5'b11000, 1'b0);
      for (int k = 0; k < 12; k++) step(1'b0, 4'd0, 5'd0, k[0] == 1'b0);

      // back-to-back frames with the second load on the last shift edge of dut_a
      step(1'b1, 4'b0110, 5'b10011, 1'b1);
      for (int k = 0; k < 3 + PAR; k++) step(1'b0, 4'd0, 5'd0, 1'b1);
      step(1'b1, 4'b1001, 5'b00101, 1'b1);
      repeat (8) step(1'b0, 4'd0, 5'd0, 1'b1);

      // parity values, then reset in the middle of a frame
      step(1'b1, 4'b1011, 5'b00011, 1'b1);
      repeat (7) step(1'b0, 4'd0, 5'd0, 1'b1);
      step(1'b1, 4'b0000, 5'b11111, 1'b1);
      repeat (2) step(1'b0, 4'd0, 5'd0, 1'b1);
      mid_reset();
      step(1'b1, 4'b0011, 5'b10100, 1'b1);
      repeat (7) step(1'b0, 4'd0, 5'd0, 1'b1);

      // randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            mid_reset();
         end else begin
            step(($urandom % 3) == 0, 4'($urandom), 5'($urandom), ($urandom % 4) != 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
